// File: rtl/int_level_ctrl_if.sv
// Bus, interrupt-source and sequencer-handshake signals of the interrupt-level controller.
// The master modport drives the controller's inputs; the slave modport is the controller side.
interface int_level_ctrl_if #(
  parameter int NLEV = 16,
  parameter int LW   = $clog2(NLEV)
);
  logic            ion;
  logic [NLEV-1:0] ib_in;
  logic            pie_wr;
  logic            pid_wr;
  logic [NLEV-1:0] hw_irq;
  logic            lvl_done;
  logic            lvl_ack;
  logic [1:0]      rd_sel;
  logic [NLEV-1:0] ib_out;
  logic            lvl_req;
  logic [LW-1:0]   lvl_new;
  logic [LW-1:0]   pil;
  logic [LW-1:0]   pvl;
  logic            busy;

  modport master (
    output ion, ib_in, pie_wr, pid_wr, hw_irq, lvl_done, lvl_ack, rd_sel,
    input  ib_out, lvl_req, lvl_new, pil, pvl, busy
  );

  modport slave (
    input  ion, ib_in, pie_wr, pid_wr, hw_irq, lvl_done, lvl_ack, rd_sel,
    output ib_out, lvl_req, lvl_new, pil, pvl, busy
  );
endinterface

// File: rtl/int_level_ctrl.sv
// Interrupt-level controller: PID/PIE registers, a priority encoder and a
// req/ack level-switch handshake that tracks the current (PIL) and previous (PVL) level.
module int_level_ctrl #(
  parameter int              NLEV   = 16,
  parameter int              LW     = $clog2(NLEV),
  parameter logic [NLEV-1:0] HWMASK = 16'hFC00,
  parameter int              SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mclr,
  int_level_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SETTLE
  } state_t;

  state_t          state, state_n;
  logic [NLEV-1:0] pid, pid_n;
  logic [NLEV-1:0] pie;
  logic [LW-1:0]   pil_q, pil_n;
  logic [LW-1:0]   pvl_q, pvl_n;
  logic            req_q, req_n;
  logic [LW-1:0]   new_q, new_n;
  logic [3:0]      cnt, cnt_n;
  logic [NLEV-1:0] act;
  logic [LW-1:0]   top;

  // Hardware set beats a software write, which beats a level-done clear.
  always_comb begin
    pid_n = pid;
    for (int i = 0; i < NLEV; i++) begin
      if (HWMASK[i] && bus.hw_irq[i])
        pid_n[i] = 1'b1;
      else if (bus.pid_wr && !HWMASK[i])
        pid_n[i] = bus.ib_in[i];
      else if (bus.lvl_done && (LW'(i) == pil_q))
        pid_n[i] = 1'b0;
    end
  end

  assign act = pid & pie;

  always_comb begin
    top = '0;
    for (int i = 0; i < NLEV; i++)
      if (act[i]) top = LW'(i);
  end

  always_comb begin
    state_n = state;
    req_n   = req_q;
    new_n   = new_q;
    pil_n   = pil_q;
    pvl_n   = pvl_q;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (bus.ion && (top != pil_q)) begin
          req_n   = 1'b1;
          new_n   = top;
          state_n = ST_REQ;
        end
      end
      // The target stays frozen here; a higher level is picked up after SETTLE.
      ST_REQ: begin
        if (bus.lvl_ack) begin
          pvl_n   = pil_q;
          pil_n   = new_q;
          req_n   = 1'b0;
          cnt_n   = 4'(SETTLE - 1);
          state_n = ST_SETTLE;
        end else if (!bus.ion) begin
          req_n   = 1'b0;
          state_n = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == 4'd0)
          state_n = ST_IDLE;
        else
          cnt_n = cnt - 4'd1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pid   <= '0;
      pie   <= '0;
      pil_q <= '0;
      pvl_q <= '0;
      req_q <= 1'b0;
      new_q <= '0;
      cnt   <= '0;
    end else if (mclr) begin
      state <= ST_IDLE;
      pid   <= '0;
      pie   <= '0;
      pil_q <= '0;
      pvl_q <= '0;
      req_q <= 1'b0;
      new_q <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pid   <= pid_n;
      if (bus.pie_wr) pie <= bus.ib_in;
      pil_q <= pil_n;
      pvl_q <= pvl_n;
      req_q <= req_n;
      new_q <= new_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    case (bus.rd_sel)
      2'd0:    bus.ib_out = pid;
      2'd1:    bus.ib_out = pie;
      2'd2:    bus.ib_out = NLEV'({pvl_q, pil_q});
      default: bus.ib_out = '0;
    endcase
  end

  assign bus.lvl_req = req_q;
  assign bus.lvl_new = new_q;
  assign bus.pil     = pil_q;
  assign bus.pvl     = pvl_q;
  assign bus.busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_int_level_ctrl.sv
// Self-checking bench for int_level_ctrl: directed handshake scenarios, then
// randomized traffic compared cycle by cycle against a behavioural model.
module tb_int_level_ctrl;

  localparam int          NLEV   = 16;
  localparam logic [15:0] HW     = 16'hFC00;
  localparam int          SETTLE = 2;

  logic clk;
  logic rst_n;
  logic mclr;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_pid, m_pie;
  logic [3:0]  m_pil, m_pvl, m_target;
  bit          m_req;
  int          m_quiet;

  int_level_ctrl_if #(.NLEV(NLEV)) bus ();

  int_level_ctrl #(.NLEV(NLEV), .HWMASK(HW), .SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mclr  (mclr),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] topOf(input logic [15:0] v);
    for (int i = 15; i >= 0; i--)
      if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  function automatic logic [15:0] expIb();
    case (bus.rd_sel)
      2'd0:    return m_pid;
      2'd1:    return m_pie;
      2'd2:    return {8'h00, m_pvl, m_pil};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic modelReset();
    m_pid = '0; m_pie = '0; m_pil = '0; m_pvl = '0;
    m_req = 0; m_target = '0; m_quiet = 0;
  endtask

  // One clock edge of the reference: pending bits by mask arithmetic, handshake as
  // "requesting" plus a count of quiet cycles left after an accepted switch.
  task automatic modelStep();
    logic [15:0] wrmask, nxt;
    logic [3:0]  t;
    if (mclr) begin
      modelReset();
      return;
    end
    t      = topOf(m_pid & m_pie);
    wrmask = bus.pid_wr ? ~HW : 16'h0000;
    nxt    = (m_pid & ~wrmask) | (bus.ib_in & wrmask);
    if (bus.lvl_done) nxt = nxt & ~((16'h0001 << m_pil) & ~wrmask);
    nxt = nxt | (bus.hw_irq & HW);
    if (m_req) begin
      if (bus.lvl_ack) begin
        m_pvl   = m_pil;
        m_pil   = m_target;
        m_req   = 0;
        m_quiet = SETTLE;
      end else if (!bus.ion) begin
        m_req = 0;
      end
    end else if (m_quiet > 0) begin
      m_quiet--;
    end else if (bus.ion && (t != m_pil)) begin
      m_req    = 1;
      m_target = t;
    end
    m_pid = nxt;
    if (bus.pie_wr) m_pie = bus.ib_in;
  endtask

  task automatic checkAll();
    checkOutput("lvl_req", bus.lvl_req, m_req);
    if (m_req) checkOutput("lvl_new", bus.lvl_new, m_target);
    checkOutput("pil", bus.pil, m_pil);
    checkOutput("pvl", bus.pvl, m_pvl);
    checkOutput("busy", bus.busy, (m_req || m_quiet > 0));
    checkOutput("ib_out", bus.ib_out, expIb());
  endtask

  task automatic clearPulses();
    bus.pie_wr = 0; bus.pid_wr = 0; bus.hw_irq = '0; bus.lvl_done = 0;
    bus.lvl_ack = 0; bus.ib_in = '0; mclr = 0;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
    clearPulses();
  endtask

  task automatic waitReq(input int maxc);
    int n = 0;
    while (!bus.lvl_req && n < maxc) begin
      applyStimulus();
      n++;
    end
    if (!bus.lvl_req) checkOutput("req_timeout", 0, 1);
  endtask

  task automatic asyncReset();
    #2 rst_n = 0;
    modelReset();
    #1;
    checkOutput("async_lvl_req", bus.lvl_req, 0);
    checkOutput("async_pil", bus.pil, 0);
    checkOutput("async_pvl", bus.pvl, 0);
    checkOutput("async_busy", bus.busy, 0);
    checkOutput("async_ib_out", bus.ib_out, expIb());
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic settle();
    for (int i = 0; i < SETTLE + 1; i++) applyStimulus();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired got=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 0;
    bus.ion = 0;
    bus.rd_sel = 2'd0;
    clearPulses();
    modelReset();
    #2;
    for (int s = 0; s < 3; s++) begin
      bus.rd_sel = 2'(s);
      #1 checkOutput("reset_ib_out", bus.ib_out, 16'h0000);
    end
    checkOutput("reset_lvl_req", bus.lvl_req, 0);
    checkOutput("reset_pil", bus.pil, 0);
    @(negedge clk);
    rst_n = 1;
    bus.rd_sel = 2'd0;

    // Up to level 5, give it up, then drop to level 3.
    bus.pie_wr = 1; bus.ib_in = 16'hFFFF; applyStimulus();
    bus.ion = 1; bus.pid_wr = 1; bus.ib_in = 16'h0028; applyStimulus();
    waitReq(4);
    checkOutput("tp_new5", bus.lvl_new, 5);
    bus.lvl_ack = 1; applyStimulus();
    checkOutput("tp_pil5", bus.pil, 5);
    checkOutput("tp_pvl0", bus.pvl, 0);
    bus.lvl_done = 1; applyStimulus();
    checkOutput("tp_pid08", bus.ib_out, 16'h0008);
    waitReq(8);
    checkOutput("tp_new3", bus.lvl_new, 3);
    bus.lvl_ack = 1; applyStimulus();
    bus.ion = 0; settle();

    // Software cannot write hardware-owned bits; hardware sets them.
    bus.pid_wr = 1; bus.ib_in = 16'hFFFF; applyStimulus();
    checkOutput("tp_pid03ff", bus.ib_out, 16'h03FF);
    bus.hw_irq = 16'h1000; applyStimulus();
    checkOutput("tp_pid13ff", bus.ib_out, 16'h13FF);
    bus.ion = 1; waitReq(4);
    checkOutput("tp_new12", bus.lvl_new, 12);
    bus.lvl_ack = 1; applyStimulus();
    settle();

    // Frozen target and exact settle latency.
    mclr = 1; applyStimulus();
    bus.pie_wr = 1; bus.ib_in = 16'hFFFF; applyStimulus();
    bus.pid_wr = 1; bus.ib_in = 16'h0028; applyStimulus();
    waitReq(4);
    bus.hw_irq = 16'h2000; applyStimulus();
    checkOutput("frozen_new5", bus.lvl_new, 5);
    bus.lvl_ack = 1; applyStimulus();
    checkOutput("frozen_pil5", bus.pil, 5);
    checkOutput("frozen_pvl0", bus.pvl, 0);
    for (int i = 0; i < SETTLE; i++) begin
      applyStimulus();
      checkOutput("settle_quiet", bus.lvl_req, 0);
    end
    applyStimulus();
    checkOutput("settle_req", bus.lvl_req, 1);
    checkOutput("settle_new13", bus.lvl_new, 13);

    // Withdraw on ion low; ack wins against a same-cycle ion fall.
    bus.ion = 0; applyStimulus();
    checkOutput("withdraw_req", bus.lvl_req, 0);
    checkOutput("withdraw_pil", bus.pil, 5);
    bus.ion = 1; applyStimulus();
    checkOutput("rerequest", bus.lvl_req, 1);
    bus.lvl_ack = 1; bus.ion = 0; applyStimulus();
    checkOutput("ackwins_pil", bus.pil, 13);
    checkOutput("ackwins_pvl", bus.pvl, 5);
    bus.ion = 1; settle();

    // Hardware set beats level-done clear at the current level.
    mclr = 1; applyStimulus();
    bus.pie_wr = 1; bus.ib_in = 16'hFFFF; applyStimulus();
    bus.hw_irq = 16'h0400; applyStimulus();
    waitReq(4);
    bus.lvl_ack = 1; applyStimulus();
    checkOutput("conf_pil10", bus.pil, 10);
    bus.hw_irq = 16'h0400; bus.lvl_done = 1; applyStimulus();
    checkOutput("set_beats_clear", bus.ib_out, 16'h0400);
    bus.lvl_done = 1; applyStimulus();
    checkOutput("done_clears", bus.ib_out, 16'h0000);
    settle();

    // Asynchronous reset while settling.
    mclr = 1; applyStimulus();
    bus.pie_wr = 1; bus.ib_in = 16'hFFFF; applyStimulus();
    bus.hw_irq = 16'h0800; applyStimulus();
    waitReq(4);
    bus.lvl_ack = 1; bus.rd_sel = 2'd2; applyStimulus();
    checkOutput("pre_async_busy", bus.busy, 1);
    asyncReset();

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      bus.ion      = ($urandom_range(0, 15) != 0);
      bus.rd_sel   = 2'($urandom_range(0, 3));
      bus.pie_wr   = ($urandom_range(0, 15) == 0);
      bus.pid_wr   = ($urandom_range(0, 7) == 0);
      bus.ib_in    = 16'($urandom);
      bus.hw_irq   = ($urandom_range(0, 5) == 0) ? 16'(1 << $urandom_range(10, 15)) : 16'h0000;
      if ($urandom_range(0, 15) == 0) bus.hw_irq = bus.hw_irq | 16'($urandom);
      bus.lvl_done = ($urandom_range(0, 5) == 0);
      bus.lvl_ack  = ($urandom_range(0, 2) == 0);
      mclr         = ($urandom_range(0, 199) == 0);
      applyStimulus();
      if ($urandom_range(0, 299) == 0) asyncReset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
